// File: rtl/axi_rd_arb_2to1.sv
// axi_rd_arb_2to1: two-client AXI4 read arbiter, round-robin on AR, R steered back via an order FIFO.
// Define AXI_RD_ARB_FIXED_PRIO_EN to give s00 fixed priority instead of round-robin.
module axi_rd_arb_2to1 #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MAX_OUTSTANDING  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_s00_arvalid,
    output logic                          o_s00_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_s00_araddr,
    input  logic [7:0]                    i_s00_arlen,
    output logic                          o_s00_rvalid,
    input  logic                          i_s00_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_s00_rdata,
    output logic                          o_s00_rlast,
    input  logic                          i_s01_arvalid,
    output logic                          o_s01_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_s01_araddr,
    input  logic [7:0]                    i_s01_arlen,
    output logic                          o_s01_rvalid,
    input  logic                          i_s01_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_s01_rdata,
    output logic                          o_s01_rlast,
    output logic                          o_m_arvalid,
    input  logic                          i_m_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_araddr,
    output logic [7:0]                    o_m_arlen,
    output logic [1:0]                    o_m_arburst,
    output logic [2:0]                    o_m_arsize,
    output logic [C_M_AXI_ID_WIDTH-1:0]   o_m_arid,
    input  logic                          i_m_rvalid,
    output logic                          o_m_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_m_rdata,
    input  logic                          i_m_rlast
);
    localparam int PW = $clog2(C_MAX_OUTSTANDING);
    localparam int CW = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic {ARB_IDLE, ARB_ISSUE} state_t;

    state_t          r_state;
    logic            r_gnt;
    logic            r_fifo [C_MAX_OUTSTANDING];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;

    logic w_any, w_full, w_pick, w_push, w_pop, w_ne, w_head;

    assign w_any  = i_s00_arvalid | i_s01_arvalid;
    assign w_full = r_cnt == CW'(C_MAX_OUTSTANDING);
    assign w_push = (r_state == ARB_ISSUE) & i_m_arready;
    assign w_ne   = r_cnt != '0;
    assign w_head = r_fifo[r_rd];
    assign w_pop  = i_m_rvalid & o_m_rready & i_m_rlast;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    assign w_pick = ~i_s00_arvalid;
`else
    logic r_prio;
    assign w_pick = (i_s00_arvalid & i_s01_arvalid) ? r_prio : i_s01_arvalid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            r_prio  <= 1'b0;
`endif
        end else begin
            if (r_state == ARB_IDLE) begin
                if (w_any && !w_full) begin
                    r_gnt   <= w_pick;
                    r_state <= ARB_ISSUE;
                end
            end else if (i_m_arready) begin
                r_state <= ARB_IDLE;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
                r_prio  <= ~r_gnt;
`endif
            end
            if (w_push) begin
                r_fifo[r_wr] <= r_gnt;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_m_arvalid   = r_state == ARB_ISSUE;
    assign o_m_araddr    = r_gnt ? i_s01_araddr : i_s00_araddr;
    assign o_m_arlen     = r_gnt ? i_s01_arlen : i_s00_arlen;
    assign o_m_arburst   = 2'b01;
    assign o_m_arsize    = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign o_m_arid      = '0;
    assign o_s00_arready = o_m_arvalid & ~r_gnt & i_m_arready;
    assign o_s01_arready = o_m_arvalid & r_gnt & i_m_arready;

    // Beats with no recorded owner are refused by holding rready low.
    assign o_m_rready   = w_ne & (w_head ? i_s01_rready : i_s00_rready);
    assign o_s00_rvalid = w_ne & ~w_head & i_m_rvalid;
    assign o_s01_rvalid = w_ne & w_head & i_m_rvalid;
    assign o_s00_rdata  = i_m_rdata;
    assign o_s01_rdata  = i_m_rdata;
    assign o_s00_rlast  = i_m_rlast;
    assign o_s01_rlast  = i_m_rlast;
endmodule

// File: tb/tb_axi_rd_arb_2to1.sv
// tb_axi_rd_arb_2to1: directed and randomized checks of axi_rd_arb_2to1 against a queue-based reference model.
module tb_axi_rd_arb_2to1;
    localparam int DEPTH = 8;
    localparam int AW = 64;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          c_arvalid [2];
    logic [AW-1:0] c_araddr  [2];
    logic [7:0]    c_arlen   [2];
    logic          c_rready  [2];
    logic          w_arready [2];
    logic          w_rvalid  [2];
    logic          w_rlast   [2];
    logic [DW-1:0] w_rdata   [2];
    logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [1:0]    m_arburst;
    logic [2:0]    m_arsize;
    logic [3:0]    m_arid;
    logic [DW-1:0] m_rdata;

    axi_rd_arb_2to1 dut (
        .clk(clk), .rst(rst),
        .i_s00_arvalid(c_arvalid[0]), .o_s00_arready(w_arready[0]), .i_s00_araddr(c_araddr[0]),
        .i_s00_arlen(c_arlen[0]), .o_s00_rvalid(w_rvalid[0]), .i_s00_rready(c_rready[0]),
        .o_s00_rdata(w_rdata[0]), .o_s00_rlast(w_rlast[0]),
        .i_s01_arvalid(c_arvalid[1]), .o_s01_arready(w_arready[1]), .i_s01_araddr(c_araddr[1]),
        .i_s01_arlen(c_arlen[1]), .o_s01_rvalid(w_rvalid[1]), .i_s01_rready(c_rready[1]),
        .o_s01_rdata(w_rdata[1]), .o_s01_rlast(w_rlast[1]),
        .o_m_arvalid(m_arvalid), .i_m_arready(m_arready), .o_m_araddr(m_araddr),
        .o_m_arlen(m_arlen), .o_m_arburst(m_arburst), .o_m_arsize(m_arsize), .o_m_arid(m_arid),
        .i_m_rvalid(m_rvalid), .o_m_rready(m_rready), .i_m_rdata(m_rdata), .i_m_rlast(m_rlast)
    );

    int checks = 0;
    int errors = 0;

    int mg = -1;
    int prio = 0;
    int order[$];

    int mem_q[$];
    int beat = 0;
    int p_req[2];
    int p_ar, p_rv, p_rr, maxlen;
    bit rand_en = 0;

    int ar_log[$];
    logic [AW-1:0] addr_log[$];
    int done_log[$];
    int beats[2];
    bit hs_c[2];
    bit hs_m, hs_r;
    int s_len;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int winner();
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        return c_arvalid[0] ? 0 : 1;
`else
        if (c_arvalid[0] && c_arvalid[1]) return prio;
        return c_arvalid[0] ? 0 : 1;
`endif
    endfunction

    // Mid-cycle: compare DUT against the model, then compute the model's next state.
    task automatic sample();
        bit ne, exp_rr, exp_rv, pop;
        int h;
        #4;
        hs_m = m_arvalid && m_arready;
        hs_r = m_rvalid && m_rready;
        s_len = int'(m_arlen);
        for (int i = 0; i < 2; i++) begin
            hs_c[i] = c_arvalid[i] && w_arready[i];
            if (hs_c[i]) begin
                ar_log.push_back(i);
                addr_log.push_back(m_araddr);
            end
            if (w_rvalid[i] && c_rready[i]) begin
                beats[i]++;
                if (w_rlast[i]) done_log.push_back(i);
            end
        end
        if (!rst) begin
            ne = order.size() > 0;
            h = ne ? order[0] : 0;
            chk("m_arvalid", m_arvalid, mg >= 0);
            if (mg >= 0) begin
                chk("m_araddr", m_araddr, c_araddr[mg]);
                chk("m_arlen", m_arlen, c_arlen[mg]);
            end
            chk("arready0", w_arready[0], mg == 0 && m_arready);
            chk("arready1", w_arready[1], mg == 1 && m_arready);
            chk("arburst", m_arburst, 2'b01);
            chk("arsize", m_arsize, 3'd6);
            chk("arid", m_arid, 4'd0);
            exp_rr = ne && c_rready[h];
            chk("m_rready", m_rready, exp_rr);
            for (int i = 0; i < 2; i++) begin
                exp_rv = ne && h == i && m_rvalid;
                chk($sformatf("rvalid%0d", i), w_rvalid[i], exp_rv);
                if (exp_rv) begin
                    chk($sformatf("rdata%0d", i), w_rdata[i], m_rdata);
                    chk($sformatf("rlast%0d", i), w_rlast[i], m_rlast);
                end
            end
            pop = m_rvalid && exp_rr && m_rlast;
            if (mg >= 0) begin
                if (m_arready) begin
                    chk("push_not_full", order.size() < DEPTH, 1'b1);
                    order.push_back(mg);
                    prio = 1 - mg;
                    mg = -1;
                end
            end else if ((c_arvalid[0] || c_arvalid[1]) && order.size() < DEPTH) begin
                mg = winner();
            end
            if (pop) void'(order.pop_front());
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs_c[i]) c_arvalid[i] = 1'b0;
            if (rand_en) begin
                if (!c_arvalid[i] && $urandom_range(99) < p_req[i]) begin
                    c_arvalid[i] = 1'b1;
                    c_araddr[i] = {$urandom, $urandom};
                    c_arlen[i] = 8'($urandom_range(maxlen));
                end
                c_rready[i] = $urandom_range(99) < p_rr;
            end
        end
        if (hs_m) mem_q.push_back(s_len);
        if (hs_r) begin
            m_rvalid = 1'b0;
            if (m_rlast) begin
                void'(mem_q.pop_front());
                beat = 0;
            end else beat++;
        end
        if (rst) begin
            mg = -1;
            prio = 0;
            order.delete();
            mem_q.delete();
            beat = 0;
            m_rvalid = 1'b0;
        end
        if (!m_rvalid && mem_q.size() > 0 && $urandom_range(99) < p_rv) begin
            m_rvalid = 1'b1;
            for (int k = 0; k < 16; k++) m_rdata[k*32 +: 32] = $urandom;
            m_rlast = beat == mem_q[0];
        end
        m_arready = $urandom_range(99) < p_ar;
        hs_c[0] = 0;
        hs_c[1] = 0;
        hs_m = 0;
        hs_r = 0;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        logic [DW-1:0] held;
        for (int i = 0; i < 2; i++) begin
            c_arvalid[i] = 0; c_araddr[i] = '0; c_arlen[i] = '0; c_rready[i] = 0;
            p_req[i] = 0; beats[i] = 0; hs_c[i] = 0;
        end
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0;
        hs_m = 0; hs_r = 0;
        p_ar = 100; p_rv = 100; p_rr = 100; maxlen = 0;

        rst = 1'b1;
        step();
        sample();
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_rready", m_rready, 1'b0);
        chk("rst_arready0", w_arready[0], 1'b0);
        chk("rst_arready1", w_arready[1], 1'b0);
        chk("rst_rvalid0", w_rvalid[0], 1'b0);
        advance();
        rst = 1'b0;

        // single s00 burst of 4 beats
        c_rready[0] = 1; c_rready[1] = 1; m_arready = 1;
        c_arvalid[0] = 1; c_araddr[0] = 64'h1000; c_arlen[0] = 8'd3;
        sample();
        chk("t1_lat0", m_arvalid, 1'b0);
        advance();
        sample();
        chk("t1_arvalid", m_arvalid, 1'b1);
        chk("t1_araddr", m_araddr, 64'h1000);
        chk("t1_arlen", m_arlen, 8'd3);
        chk("t1_arsize", m_arsize, 3'd6);
        advance();
        repeat (10) step();
        chk("t1_beats0", beats[0], 4);
        chk("t1_beats1", beats[1], 0);
        chk("t1_done", done_log.size(), 1);
        chk("t1_model_empty", order.size(), 0);

        // simultaneous requests after reset
        do_reset();
        ar_log.delete(); addr_log.delete(); done_log.delete();
        c_arvalid[0] = 1; c_araddr[0] = 64'h0; c_arlen[0] = 0;
        c_arvalid[1] = 1; c_araddr[1] = 64'h8000; c_arlen[1] = 0;
        repeat (12) step();
        chk("t2_nar", ar_log.size(), 2);
        chk("t2_ndone", done_log.size(), 2);
        if (ar_log.size() == 2 && done_log.size() == 2) begin
            chk("t2_first", ar_log[0], 0);
            chk("t2_second", ar_log[1], 1);
            chk("t2_addr0", addr_log[0], 64'h0);
            chk("t2_addr1", addr_log[1], 64'h8000);
            chk("t2_done0", done_log[0], 0);
            chk("t2_done1", done_log[1], 1);
        end

        // fill the order FIFO from s01 with memory silent
        do_reset();
        ar_log.delete(); done_log.delete();
        p_rv = 0; p_ar = 100; p_rr = 100; maxlen = 0;
        p_req[0] = 0; p_req[1] = 100; rand_en = 1;
        repeat (20) step();
        chk("t3_issued", ar_log.size(), 8);
        chk("t3_model_full", order.size(), DEPTH);
        repeat (4) begin
            sample();
            chk("t3_full_hold", m_arvalid, 1'b0);
            advance();
        end
        p_rv = 100;
        sample();
        advance();
        p_rv = 0;
        step();
        found = 0;
        repeat (2) begin
            sample();
            if (m_arvalid) found = 1;
            advance();
        end
        chk("t3_ninth", found, 1'b1);

        // s00 stalls rready for 3 cycles mid-burst
        rand_en = 0;
        p_req[1] = 0;
        do_reset();
        c_arvalid[1] = 0;
        p_ar = 100; p_rv = 100;
        beats[0] = 0; beats[1] = 0;
        c_rready[0] = 1; c_rready[1] = 1;
        c_arvalid[0] = 1; c_araddr[0] = 64'h2000; c_arlen[0] = 8'd3;
        for (int k = 0; k < 20 && beats[0] < 2; k++) step();
        chk("t4_two_beats", beats[0], 2);
        c_rready[0] = 0;
        sample();
        held = m_rdata;
        chk("t4_stall_rready", m_rready, 1'b0);
        advance();
        repeat (2) begin
            sample();
            chk("t4_stall_rready", m_rready, 1'b0);
            chk("t4_stall_hold", m_rdata, held);
            advance();
        end
        c_rready[0] = 1;
        sample();
        chk("t4_resume_rvalid", w_rvalid[0], 1'b1);
        chk("t4_resume_data", w_rdata[0], held);
        advance();
        repeat (6) step();
        chk("t4_beats", beats[0], 4);

        // reset with two bursts outstanding
        do_reset();
        p_rv = 0;
        c_arvalid[0] = 1; c_araddr[0] = 64'h10; c_arlen[0] = 0;
        c_arvalid[1] = 1; c_araddr[1] = 64'h20; c_arlen[1] = 0;
        repeat (6) step();
        chk("t5_outstanding", order.size(), 2);
        c_arvalid[1] = 1; c_araddr[1] = 64'h3000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("t5_rready", m_rready, 1'b0);
        chk("t5_arready0", w_arready[0], 1'b0);
        chk("t5_arready1", w_arready[1], 1'b0);
        chk("t5_arvalid", m_arvalid, 1'b0);
        advance();
        sample();
        chk("t5_regrant", m_arvalid, 1'b1);
        chk("t5_addr", m_araddr, 64'h3000);
        advance();

        // both clients hold arvalid continuously
        do_reset();
        ar_log.delete();
        p_req[0] = 100; p_req[1] = 100; p_ar = 100; p_rv = 100; p_rr = 100; maxlen = 0;
        rand_en = 1;
        repeat (13) step();
        chk("t6_count", ar_log.size() >= 6, 1'b1);
        if (ar_log.size() >= 6)
            for (int k = 0; k < 6; k++)
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                chk($sformatf("t6_grant%0d", k), ar_log[k], 0);
`else
                chk($sformatf("t6_grant%0d", k), ar_log[k], k % 2);
`endif

        // randomized traffic
        do_reset();
        for (int b = 0; b < 40; b++) begin
            p_req[0] = $urandom_range(100);
            p_req[1] = $urandom_range(100);
            p_ar = $urandom_range(100, 20);
            p_rv = $urandom_range(100);
            p_rr = $urandom_range(100, 20);
            maxlen = $urandom_range(3);
            repeat (60) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
